// File: rtl/osc_pkg.sv
// Shared types and defaults for the per-voice wave oscillator.
package osc_pkg;

   // Waveform selector driven by the voice decode logic.
   typedef enum logic [1:0] {
      SAW    = 2'd0,
      SQUARE = 2'd1,
      TRI    = 2'd2,
      PULSE  = 2'd3
   } wave_t;

   // Prescaler limit at oct_dwn=0; one phase step every limit+1 clocks.
   localparam int unsigned DEFAULT_BASE_COUNT = 149;

   // Largest prescaler limit reachable for a given octave-select width.
   function automatic longint unsigned max_limit(input int unsigned base,
                                                 input int unsigned oct_w);
      return longint'(base) << ((64'd1 << oct_w) - 64'd1);
   endfunction

endpackage

// File: rtl/osc_prescaler.sv
// Clock prescaler: counts up to a runtime limit and emits one tick per
// limit+1 clocks. Disable and sync both restart the count from zero.
module osc_prescaler #(
   parameter int unsigned DIV_W = 11
) (
   input  logic             clk,
   input  logic             nRst,
   input  logic             enable,
   input  logic             sync,
   input  logic [DIV_W-1:0] limit,
   output logic             tick
);

   logic [DIV_W-1:0] count_q;
   logic [DIV_W-1:0] count_d;
   logic             tick_d;

   // Next-count and tick decode; ">=" lets a lowered limit tick at once
   // instead of letting the counter run past it.
   always_comb begin
      count_d = count_q + DIV_W'(1);
      tick_d  = 1'b0;
      if (!enable) begin
         count_d = '0;
      end else if (sync) begin
         count_d = '0;
      end else if (count_q >= limit) begin
         count_d = '0;
         tick_d  = 1'b1;
      end
   end

   // Prescaler count register.
   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign tick = tick_d;

endmodule

// File: rtl/wave_oscillator.sv
// Per-voice oscillator: prescaled phase accumulator feeding a saw, square,
// triangle or variable-pulse shaper with a registered output and a
// once-per-period strobe for the mixer and envelope.
module wave_oscillator
   import osc_pkg::*;
#(
   parameter int unsigned BASE_COUNT = DEFAULT_BASE_COUNT,
   parameter int unsigned OUT_W      = 8,
   parameter int unsigned OCT_W      = 2,
   parameter int unsigned DIV_W      = 11
) (
   input  logic             clk,
   input  logic             nRst,
   input  logic             enable,
   input  logic [OCT_W-1:0] oct_dwn,
   input  wave_t            wave_sel,
   input  logic [OUT_W-1:0] pulse_width,
   input  logic             sync,
   output logic [OUT_W-1:0] wave_out,
   output logic             cycle_strobe
);

   localparam longint unsigned LIMIT_MAX = max_limit(BASE_COUNT, OCT_W);
   localparam longint unsigned DIV_RANGE = 64'd1 << DIV_W;

   // Elaboration-time sanity checks on the parameter set.
   if (OUT_W < 2) begin : g_chk_out_w
      $error("wave_oscillator: OUT_W must be at least 2");
   end
   if (LIMIT_MAX >= DIV_RANGE) begin : g_chk_div_w
      $error("wave_oscillator: DIV_W too narrow for BASE_COUNT at lowest octave");
   end

   logic [DIV_W-1:0] limit;
   logic             tick;

   logic [OUT_W-1:0] phase_q;
   logic [OUT_W-1:0] phase_d;
   logic             wrap_q;
   logic             wrap_d;
   logic [OUT_W-1:0] wave_q;
   logic [OUT_W-1:0] wave_d;
   logic             strobe_q;
   logic             strobe_d;

   logic [OUT_W-1:0] shape;
   logic [OUT_W-1:0] phase_dbl;
   logic             phase_msb;

   assign limit = DIV_W'(BASE_COUNT) << oct_dwn;

   osc_prescaler #(
      .DIV_W(DIV_W)
   ) u_prescaler (
      .clk   (clk),
      .nRst  (nRst),
      .enable(enable),
      .sync  (sync),
      .limit (limit),
      .tick  (tick)
   );

   // Phase accumulator next state; tick is already suppressed by sync
   // and disable inside the prescaler, so a wrap is always tick-driven.
   always_comb begin
      phase_d = phase_q;
      wrap_d  = 1'b0;
      if (!enable || sync) begin
         phase_d = '0;
      end else if (tick) begin
         phase_d = phase_q + OUT_W'(1);
         wrap_d  = (phase_q == '1);
      end
   end

   // Waveform shaper from the current phase.
   always_comb begin
      phase_msb = phase_q[OUT_W-1];
      phase_dbl = {phase_q[OUT_W-2:0], 1'b0};
      shape     = '0;
      case (wave_sel)
         SAW:     shape = phase_q;
         SQUARE:  shape = phase_msb ? '1 : '0;
         TRI:     shape = phase_msb ? ~phase_dbl : phase_dbl;
         PULSE:   shape = (phase_q < pulse_width) ? '1 : '0;
         default: shape = '0;
      endcase
   end

   // Output stage next state; the strobe lines up with the sample that
   // first shows phase 0 after a wrap, one cycle after the wrap itself.
   always_comb begin
      wave_d   = '0;
      strobe_d = 1'b0;
      if (enable) begin
         wave_d   = shape;
         strobe_d = wrap_q;
      end
   end

   // Phase, wrap flag and registered outputs.
   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
         phase_q  <= '0;
         wrap_q   <= 1'b0;
         wave_q   <= '0;
         strobe_q <= 1'b0;
      end else begin
         phase_q  <= phase_d;
         wrap_q   <= wrap_d;
         wave_q   <= wave_d;
         strobe_q <= strobe_d;
      end
   end

   assign wave_out     = wave_q;
   assign cycle_strobe = strobe_q;

endmodule

// File: tb/tb_wave_oscillator.sv
// Directed bench for wave_oscillator with BASE_COUNT=3, OUT_W=4.
module tb_wave_oscillator;
   import osc_pkg::*;

   logic       clk = 1'b0;
   logic       nRst;
   logic       enable;
   logic [1:0] oct_dwn;
   wave_t      wave_sel;
   logic [3:0] pulse_width;
   logic       sync;
   logic [3:0] wave_out;
   logic       cycle_strobe;

   int total = 0;
   int bad   = 0;

   typedef struct {
      wave_t       sel;
      logic [3:0]  pw;
      int unsigned ph;
      logic [3:0]  exp;
   } vec_t;

   vec_t vecs[21];

   wave_oscillator #(
      .BASE_COUNT(3),
      .OUT_W     (4),
      .OCT_W     (2),
      .DIV_W     (6)
   ) dut (
      .clk         (clk),
      .nRst        (nRst),
      .enable      (enable),
      .oct_dwn     (oct_dwn),
      .wave_sel    (wave_sel),
      .pulse_width (pulse_width),
      .sync        (sync),
      .wave_out    (wave_out),
      .cycle_strobe(cycle_strobe)
   );

   always #5 clk = ~clk;

   task automatic tick_n(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [3:0] exp_w, input logic exp_s);
      total++;
      if (wave_out !== exp_w || cycle_strobe !== exp_s) begin
         bad++;
         $display("FAIL %s: wave_out=%0d cycle_strobe=%0b required wave_out=%0d cycle_strobe=%0b",
                  name, wave_out, cycle_strobe, exp_w, exp_s);
      end
   endtask

   task automatic sync_pulse();
      sync = 1'b1;
      tick_n(1);
      sync = 1'b0;
   endtask

   initial begin
      vecs[0]  = '{SAW,    4'd0,  3,  4'd3};
      vecs[1]  = '{SAW,    4'd0,  15, 4'd15};
      vecs[2]  = '{SAW,    4'd0,  0,  4'd0};
      vecs[3]  = '{SQUARE, 4'd0,  7,  4'd0};
      vecs[4]  = '{SQUARE, 4'd0,  8,  4'd15};
      vecs[5]  = '{SQUARE, 4'd0,  0,  4'd0};
      vecs[6]  = '{SQUARE, 4'd0,  15, 4'd15};
      vecs[7]  = '{TRI,    4'd0,  0,  4'd0};
      vecs[8]  = '{TRI,    4'd0,  1,  4'd2};
      vecs[9]  = '{TRI,    4'd0,  7,  4'd14};
      vecs[10] = '{TRI,    4'd0,  8,  4'd15};
      vecs[11] = '{TRI,    4'd0,  9,  4'd13};
      vecs[12] = '{TRI,    4'd0,  15, 4'd1};
      vecs[13] = '{PULSE,  4'd5,  0,  4'd15};
      vecs[14] = '{PULSE,  4'd5,  4,  4'd15};
      vecs[15] = '{PULSE,  4'd5,  5,  4'd0};
      vecs[16] = '{PULSE,  4'd5,  15, 4'd0};
      vecs[17] = '{PULSE,  4'd0,  0,  4'd0};
      vecs[18] = '{PULSE,  4'd0,  7,  4'd0};
      vecs[19] = '{PULSE,  4'd15, 14, 4'd15};
      vecs[20] = '{PULSE,  4'd15, 15, 4'd0};

      nRst        = 1'b1;
      enable      = 1'b1;
      oct_dwn     = 2'd0;
      wave_sel    = SAW;
      pulse_width = 4'd0;
      sync        = 1'b0;

      // Reset state.
      #1 nRst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("reset", 4'd0, 1'b0);
      #4 nRst = 1'b1;

      // Saw from release: one step per 4 clocks, strobe at each wrap.
      for (int k = 1; k <= 140; k++) begin
         tick_n(1);
         check("period", 4'(((k - 1) / 4) % 16), 1'((k == 65) || (k == 129)));
      end

      // Shaper table: sync restarts phase, then run to the wanted phase.
      for (int i = 0; i < 21; i++) begin
         wave_sel    = vecs[i].sel;
         pulse_width = vecs[i].pw;
         sync_pulse();
         tick_n(int'(4 * vecs[i].ph + 1));
         check($sformatf("shape[%0d]", i), vecs[i].exp, 1'b0);
      end

      // Octave down by 2: step every 13 clocks.
      wave_sel = SAW;
      oct_dwn  = 2'd2;
      sync_pulse();
      for (int j = 1; j <= 27; j++) begin
         tick_n(1);
         check("oct2", 4'((j - 1) / 13), 1'b0);
      end

      // Lowering octave with count above the new limit ticks next cycle.
      sync_pulse();
      tick_n(10);
      oct_dwn = 2'd0;
      tick_n(1);
      check("octsw_a", 4'd0, 1'b0);
      tick_n(1);
      check("octsw_b", 4'd1, 1'b0);
      tick_n(3);
      check("octsw_c", 4'd1, 1'b0);
      tick_n(1);
      check("octsw_d", 4'd2, 1'b0);
      tick_n(4);
      check("octsw_e", 4'd3, 1'b0);

      // Sync at phase 9.
      sync_pulse();
      tick_n(36);
      check("sync9_pre", 4'd8, 1'b0);
      sync = 1'b1;
      tick_n(1);
      check("sync9_edge", 4'd9, 1'b0);
      sync = 1'b0;
      tick_n(1);
      check("sync9_zero", 4'd0, 1'b0);
      tick_n(3);
      check("sync9_hold", 4'd0, 1'b0);
      tick_n(1);
      check("sync9_step", 4'd1, 1'b0);

      // Sync coincident with the wrapping tick: no strobe.
      sync_pulse();
      tick_n(63);
      check("synctick_pre", 4'd15, 1'b0);
      sync = 1'b1;
      tick_n(1);
      check("synctick_edge", 4'd15, 1'b0);
      sync = 1'b0;
      tick_n(1);
      check("synctick_zero", 4'd0, 1'b0);
      tick_n(1);
      check("synctick_nostb", 4'd0, 1'b0);
      tick_n(3);
      check("synctick_step", 4'd1, 1'b0);

      // Enable dropped at phase 7, then restarted.
      sync_pulse();
      tick_n(28);
      check("en_pre", 4'd6, 1'b0);
      enable = 1'b0;
      tick_n(1);
      check("en_off", 4'd0, 1'b0);
      tick_n(3);
      check("en_off_hold", 4'd0, 1'b0);
      enable = 1'b1;
      tick_n(4);
      check("en_restart_a", 4'd0, 1'b0);
      tick_n(1);
      check("en_restart_b", 4'd1, 1'b0);

      // Async reset while the strobe is high.
      wave_sel    = PULSE;
      pulse_width = 4'd5;
      sync_pulse();
      tick_n(65);
      check("rst_pre", 4'd15, 1'b1);
      #2 nRst = 1'b0;
      #1;
      check("rst_async", 4'd0, 1'b0);
      wave_sel = SAW;
      #2 nRst = 1'b1;
      tick_n(4);
      check("rst_rel_a", 4'd0, 1'b0);
      tick_n(1);
      check("rst_rel_b", 4'd1, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
